// File: rtl/scaled_ring_buffer.sv
// Handshaked sample buffer: each accepted sample is transformed by a phase-dependent rule
// (pass, halve, shift, zero) and queued in a DEPTH-entry first-word-fall-through ring.
module scaled_ring_buffer #(
    parameter int unsigned       WIDTH   = 32,
    parameter int unsigned       DEPTH   = 4,
    parameter int unsigned       CNT_W   = 8,
    parameter logic [CNT_W-1:0]  TH_HALF = 8'h80,
    parameter logic [CNT_W-1:0]  TH_SHR  = 8'hC0,
    parameter int unsigned       SHR_AMT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic [1:0]               mode_ovr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         phase
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] PH_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        XF_PASS,
        XF_HALF,
        XF_SHR,
        XF_ZERO
    } xf_sel_e;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    xf_sel_e          xf_sel;
    logic [WIDTH-1:0] xf_data;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        xf_sel = XF_ZERO;
        unique case (mode_ovr)
            2'b01:   xf_sel = XF_PASS;
            2'b10:   xf_sel = XF_HALF;
            2'b11:   xf_sel = XF_ZERO;
            default: begin
                if (phase_q == '0)
                    xf_sel = XF_PASS;
                else if (phase_q < TH_HALF)
                    xf_sel = XF_HALF;
                else if (phase_q < TH_SHR)
                    xf_sel = XF_SHR;
                else
                    xf_sel = XF_ZERO;
            end
        endcase
    end

    always_comb begin
        xf_data = '0;
        unique case (xf_sel)
            XF_PASS: xf_data = in_data;
            XF_HALF: xf_data = in_data >> 1;
            XF_SHR:  xf_data = in_data >> SHR_AMT;
            default: xf_data = '0;
        endcase
    end

    // clr overrides any same-cycle push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        phase_d  = phase_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            phase_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                phase_d  = phase_q + PH_ONE;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count_d = count_q + OCC_ONE;
                2'b01:   count_d = count_q - OCC_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            phase_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            phase_q  <= phase_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr)
            mem_q[wr_ptr_q] <= xf_data;
    end

    // Storage is never reset, so the read is gated to keep stale/X data off the port
    assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;
    assign phase    = phase_q;

endmodule

// File: tb/tb_scaled_ring_buffer.sv
// Self-checking bench for scaled_ring_buffer: table of transform vectors plus
// hand-written full/clear/reset sequences, with a queue scoreboard on every pop.
module tb_scaled_ring_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic [1:0]  mode_ovr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  count;
    logic [7:0]  phase;

    int unsigned total = 0;
    int unsigned bad   = 0;

    int          m_count = 0;
    logic [7:0]  m_phase = '0;
    logic [31:0] sb[$];

    typedef struct {
        bit          do_clr;
        logic [7:0]  ph;
        logic [31:0] data;
        logic [1:0]  ovr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    scaled_ring_buffer #(
        .WIDTH   (32),
        .DEPTH   (4),
        .CNT_W   (8),
        .TH_HALF (8'h80),
        .TH_SHR  (8'hC0),
        .SHR_AMT (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .mode_ovr  (mode_ovr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_f(input logic [31:0] d, input logic [1:0] o,
                                            input logic [7:0] ph);
        case (o)
            2'b01:   return d;
            2'b10:   return d >> 1;
            2'b11:   return 32'h0;
            default: begin
                if (ph == 8'h00)      return d;
                else if (ph < 8'h80)  return d / 2;
                else if (ph < 8'hC0)  return d >> 2;
                else                  return 32'h0;
            end
        endcase
    endfunction

    // One clock: drive after negedge, check/model before posedge, check state at next negedge
    task automatic xfer(input logic v, input logic [31:0] d, input logic [1:0] o, input logic r);
        bit do_push, do_pop;
        in_valid  = v;
        in_data   = d;
        mode_ovr  = o;
        out_ready = r;
        #1;
        chk("in_ready", {31'b0, in_ready}, {31'b0, m_count != 4});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_count != 0});
        do_push = v && (m_count != 4);
        do_pop  = r && (m_count != 0);
        if (do_pop) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else                chk("pop_data", out_data, sb.pop_front());
        end
        if (do_push) begin
            sb.push_back(model_f(d, o, m_phase));
            m_phase = m_phase + 8'd1;
        end
        m_count = m_count + int'(do_push) - int'(do_pop);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("count", {29'b0, count}, 32'(m_count));
        chk("phase", {24'b0, phase}, {24'b0, m_phase});
    endtask

    task automatic do_clr();
        clr       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        m_count = 0;
        m_phase = '0;
        sb.delete();
        chk("clr_count", {29'b0, count}, 32'd0);
        chk("clr_phase", {24'b0, phase}, 32'd0);
        chk("clr_out_valid", {31'b0, out_valid}, 32'd0);
        chk("clr_out_data", out_data, 32'd0);
    endtask

    task automatic advance_to(input logic [7:0] target);
        while (m_phase != target) xfer(1'b1, $urandom, 2'b00, 1'b1);
        while (m_count != 0)      xfer(1'b0, 32'h0, 2'b00, 1'b1);
    endtask

    initial begin
        vecs[0]  = '{0, 8'h00, 32'h0000_0100, 2'b00, 32'h0000_0100};
        vecs[1]  = '{0, 8'h01, 32'h0000_0100, 2'b00, 32'h0000_0080};
        vecs[2]  = '{0, 8'h7F, 32'h0000_0101, 2'b00, 32'h0000_0080};
        vecs[3]  = '{0, 8'h80, 32'h0000_0100, 2'b00, 32'h0000_0040};
        vecs[4]  = '{0, 8'hBF, 32'h0000_0101, 2'b00, 32'h0000_0040};
        vecs[5]  = '{0, 8'hC0, 32'hFFFF_FFFF, 2'b00, 32'h0000_0000};
        vecs[6]  = '{0, 8'hFF, 32'h0000_0020, 2'b00, 32'h0000_0000};
        vecs[7]  = '{0, 8'h00, 32'h0000_0020, 2'b00, 32'h0000_0020};
        vecs[8]  = '{1, 8'h00, 32'h0000_0009, 2'b10, 32'h0000_0004};
        vecs[9]  = '{0, 8'h01, 32'h0000_0009, 2'b11, 32'h0000_0000};
        vecs[10] = '{0, 8'hC5, 32'h1234_5678, 2'b01, 32'h1234_5678};

        reset = 1'b0; clr = 1'b0; mode_ovr = 2'b00;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // reset held: activity on the inputs must not move anything
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid  = ~in_valid;
            out_ready = 1'b1;
            in_data   = 32'hA5A5_0000 + 32'(i);
            #1;
            chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
            chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_out_data", out_data, 32'd0);
            chk("rst_count", {29'b0, count}, 32'd0);
            chk("rst_phase", {24'b0, phase}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].do_clr) do_clr();
            advance_to(vecs[i].ph);
            xfer(1'b1, vecs[i].data, vecs[i].ovr, 1'b0);
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
            xfer(1'b0, 32'h0, 2'b00, 1'b1);
        end

        // fill to DEPTH with nothing draining
        for (int i = 1; i <= 4; i++) xfer(1'b1, 32'(i), 2'b01, 1'b0);
        chk("full_count", {29'b0, count}, 32'd4);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        xfer(1'b1, 32'd5, 2'b01, 1'b0);
        xfer(1'b1, 32'd6, 2'b01, 1'b1);
        chk("full_pop_count", {29'b0, count}, 32'd3);
        chk("full_pop_in_ready", {31'b0, in_ready}, 32'd1);
        chk("head_after_pop", out_data, 32'd2);

        // clr with push+pop pending and three entries held
        do_clr();
        xfer(1'b1, 32'h77, 2'b00, 1'b0);
        chk("after_clr_head", out_data, 32'h77);

        for (int i = 0; i < 2; i++) xfer(1'b1, 32'(i + 8), 2'b01, 1'b0);
        chk("pre_rst_count", {29'b0, count}, 32'd3);
        in_valid = 1'b1; out_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        m_count = 0; m_phase = '0; sb.delete();
        chk("async_count", {29'b0, count}, 32'd0);
        chk("async_phase", {24'b0, phase}, 32'd0);
        chk("async_out_valid", {31'b0, out_valid}, 32'd0);
        chk("async_out_data", out_data, 32'd0);
        chk("async_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        chk("held_out_valid", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b0; out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        xfer(1'b1, 32'h0000_0400, 2'b00, 1'b0);
        xfer(1'b1, 32'h0000_0400, 2'b00, 1'b1);
        xfer(1'b0, 32'h0, 2'b00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
